// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-register CPU: sequencer state encoding,
// instruction field positions and ALU opcodes.
package cpu_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  typedef enum logic [2:0] {
    StIdle  = IDLE,
    StFetch = FETCH,
    StWait  = WAIT,
    StExec  = EXEC,
    StDone  = DONE
  } state_e;

  localparam int unsigned DST_HI = 7;
  localparam int unsigned DST_LO = 6;
  localparam int unsigned OP_HI  = 5;
  localparam int unsigned OP_LO  = 4;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute controller: owns PC and IR, sequences the program
// SRAM and shares its single port with the program-load path while idle.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PROG_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        alu_op,
  output logic              rf_we,
  output logic [1:0]        rf_waddr,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastPc = ADDR_W'(PROG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              halt_pend_q, halt_pend_d;

  logic unused_ir;
  assign unused_ir = ^ir_q[OP_LO-1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    halt_pend_d = halt_pend_q;
    load_ready  = 1'b0;
    mem_cs      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    alu_op      = 2'b00;
    rf_we       = 1'b0;
    rf_waddr    = 2'b00;
    pc          = pc_q;
    busy        = 1'b0;
    done        = 1'b0;

    if (state_q != StIdle && halt_req) begin
      halt_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Load owns the SRAM port; a coincident start must be held until load drops.
        if (load_valid) begin
          load_ready = 1'b1;
          mem_cs     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = load_addr;
          mem_wdata  = load_data;
        end else if (start) begin
          pc_d        = '0;
          halt_pend_d = 1'b0;
          state_d     = StFetch;
        end
      end
      StFetch: begin
        busy     = 1'b1;
        mem_cs   = 1'b1;
        mem_addr = pc_q;
        state_d  = StWait;
      end
      StWait: begin
        busy    = 1'b1;
        ir_d    = mem_rdata;
        state_d = StExec;
      end
      StExec: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        alu_op   = ir_q[OP_HI:OP_LO];
        rf_waddr = ir_q[DST_HI:DST_LO];
        if (pc_q == LastPc || halt_pend_q || halt_req) begin
          state_d = StDone;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset suppresses everything immediately so an aborted EXEC never writes back.
    if (reset) begin
      load_ready = 1'b0;
      mem_cs     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      alu_op     = 2'b00;
      rf_we      = 1'b0;
      rf_waddr   = 2'b00;
      pc         = '0;
      busy       = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ir_q        <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      halt_pend_q <= halt_pend_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomised bench for cpu_sequencer: a run-schedule model predicts every output
// each cycle, and directed scenarios pin the model with literal expectations.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, halt_req, load_valid;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic       load_ready, mem_cs, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [1:0] alu_op, rf_waddr;
  logic       rf_we, busy, done;
  logic [3:0] pc;

  cpu_sequencer #(.ADDR_W(4), .DATA_W(8), .PROG_LEN(16)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_op(alu_op), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Synchronous program SRAM driven purely by the DUT's port.
  logic [7:0] sram [16];
  always @(posedge clk) begin
    if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_cs && !mem_we) mem_rdata <= sram[mem_addr];
  end

  // Reference model: a run is a numbered cycle count t>=1 since start was accepted;
  // instruction k is fetched at t=3k+1 and executed at t=3k+3.
  logic [7:0] prog [16];
  bit         run = 0, done_next = 0, halt_seen = 0;
  int         t = 0;
  int         m_pc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      run = 0; done_next = 0; halt_seen = 0; m_pc = 0;
    end else if (done_next) begin
      done_next = 0;
    end else if (run) begin
      if (halt_req) halt_seen = 1;
      if ((t - 1) % 3 == 2 && ((t - 1) / 3 == 15 || halt_seen)) begin
        m_pc = (t - 1) / 3;
        run = 0;
        done_next = 1;
      end else begin
        t++;
      end
    end else if (load_valid) begin
      prog[load_addr] = load_data;
    end else if (start) begin
      run = 1; t = 1; halt_seen = 0; m_pc = 0;
    end
  end

  always @(negedge clk) begin
    logic       e_lr, e_cs, e_we, e_rfwe, e_busy, e_done;
    logic [3:0] e_addr, e_pc;
    logic [7:0] e_wdata;
    logic [1:0] e_op, e_dst;
    int         idx;
    e_lr = 0; e_cs = 0; e_we = 0; e_rfwe = 0; e_busy = 0; e_done = 0;
    e_addr = 0; e_wdata = 0; e_op = 0; e_dst = 0; e_pc = 4'(m_pc);
    if (cyc >= 1) begin
      if (reset) begin
        e_pc = 0;
      end else if (done_next) begin
        e_done = 1;
      end else if (run) begin
        idx = (t - 1) / 3;
        e_busy = 1;
        e_pc = 4'(idx);
        if ((t - 1) % 3 == 0) begin
          e_cs = 1; e_addr = 4'(idx);
        end else if ((t - 1) % 3 == 2) begin
          e_rfwe = 1; e_dst = prog[idx][7:6]; e_op = prog[idx][5:4];
        end
      end else if (load_valid) begin
        e_lr = 1; e_cs = 1; e_we = 1; e_addr = load_addr; e_wdata = load_data;
      end
      chk("load_ready", load_ready, e_lr);
      chk("mem_cs", mem_cs, e_cs);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("rf_we", rf_we, e_rfwe);
      chk("rf_waddr", rf_waddr, e_dst);
      chk("alu_op", alu_op, e_op);
      chk("pc", pc, e_pc);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
    end
  end

  // Event counters used by the directed literal checks.
  int rf_cnt = 0, done_cnt = 0, bad_we = 0, lr_cnt = 0;
  int first_rf = -1, last_rf = -1, done_cyc = -1;
  always @(negedge clk) begin
    if (!reset) begin
      if (rf_we) begin
        rf_cnt++;
        last_rf = cyc;
        if (first_rf < 0) first_rf = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy && mem_we) bad_we++;
      if (load_ready) lr_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rf_cnt = 0; done_cnt = 0; bad_we = 0; lr_cnt = 0;
    first_rf = -1; last_rf = -1; done_cyc = -1;
  endtask

  task automatic wait_done(input int bound);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < bound && done_cnt == d0; i++) step();
    chk("done_within_bound", 32'(done_cnt != d0), 1);
    step();
  endtask

  task automatic load_all(input logic [7:0] base, input logic [7:0] inc);
    for (int i = 0; i < 16; i++) begin
      load_valid = 1; load_addr = 4'(i); load_data = base + 8'(i) * inc;
      step();
    end
    load_valid = 0;
  endtask

  int ts;

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram[i] = 8'h00;
      prog[i] = 8'h00;
    end
    reset = 1; start = 0; halt_req = 0; load_valid = 0; load_addr = 0; load_data = 0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_pc", pc, 0);
    reset = 0;
    step();

    // Load 0x00..0x0F then execute it.
    clr();
    load_all(8'h00, 8'h01);
    chk("load_ready_count", lr_cnt, 16);
    start = 1; step(); start = 0;
    wait_done(80);
    chk("t1_rf_count", rf_cnt, 16);

    // All-0x40 program: dest reg 1, 16 writes three cycles apart.
    load_all(8'h40, 8'h00);
    clr();
    start = 1; ts = cyc; step(); start = 0;
    wait_done(80);
    chk("t2_first_rf_offset", first_rf - ts, 3);
    chk("t2_last_rf_offset", last_rf - ts, 48);
    chk("t2_rf_count", rf_cnt, 16);
    chk("t2_done_count", done_cnt, 1);
    chk("t2_done_after_last", done_cyc - last_rf, 1);
    chk("t2_pc", pc, 15);

    // halt_req during WAIT of instruction 5.
    clr();
    start = 1; ts = cyc; step(); start = 0;
    repeat (16) step();
    halt_req = 1; step(); halt_req = 0;
    wait_done(20);
    chk("t3_rf_count", rf_cnt, 6);
    chk("t3_done_after_last", done_cyc - last_rf, 1);
    chk("t3_pc", pc, 5);

    // load and start in the same idle cycle: load wins, start held.
    load_valid = 1; start = 1; load_addr = 4'd3; load_data = 8'h80; #1;
    chk("t4_load_ready", load_ready, 1);
    chk("t4_busy", busy, 0);
    step(); load_valid = 0;
    step(); start = 0;
    chk("t4_fetch_cs", mem_cs, 1);
    chk("t4_fetch_addr", mem_addr, 0);
    wait_done(80);

    // Reset during EXEC of instruction 7.
    clr();
    start = 1; ts = cyc; step(); start = 0;
    repeat (23) step();
    reset = 1; #1;
    chk("t5_rf_we_in_reset", rf_we, 0);
    step(); reset = 0; #1;
    chk("t5_busy", busy, 0);
    chk("t5_pc", pc, 0);
    repeat (3) step();
    chk("t5_done_count", done_cnt, 0);
    chk("t5_rf_count", rf_cnt, 7);

    // start and load while busy are ignored.
    clr();
    start = 1; step(); start = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i % 4 == 1); load_valid = (i % 3 == 0);
      load_addr = 4'(i); load_data = 8'hFF; #1;
      chk("t6_load_ready_busy", load_ready, 0);
      step();
    end
    start = 0; load_valid = 0;
    wait_done(80);
    chk("t6_rf_count", rf_cnt, 16);
    chk("t6_mem_we_busy", bad_we, 0);
    chk("t6_done_count", done_cnt, 1);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      start      = ($urandom_range(0, 4) == 0);
      halt_req   = ($urandom_range(0, 39) == 0);
      load_addr  = 4'($urandom_range(0, 15));
      load_data  = 8'($urandom_range(0, 255));
      step();
    end
    reset = 0; load_valid = 0; start = 0; halt_req = 0;
    repeat (60) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
